// File: rtl/btn_in_rpt.sv
// btn_in_rpt: N-channel active-low push-button synchroniser and debouncer with press,
// release and level outputs. Define BTN_AUTO_REPEAT_EN to add hold-to-auto-repeat on BOUT.
module btn_in_rpt #(
    parameter int N         = 3,
    parameter int DIV       = 1250000,
    parameter int STABLE    = 2,
    parameter int RPT_DELAY = 20,
    parameter int RPT_RATE  = 4
) (
    input  logic         CLOCK_50,
    input  logic         RST,
    input  logic [N-1:0] BIN,
    output logic [N-1:0] BOUT,
    output logic [N-1:0] BREL,
    output logic [N-1:0] BLVL,
    output logic         TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;
`endif

    logic [N-1:0]  meta_q;
    logic [N-1:0]  sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick;
    logic          tick_q;

    assign tick  = (cnt_q == CW'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Synchroniser resets to "released" so no phantom press follows reset.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            meta_q <= '1;
            sync_q <= '1;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            meta_q <= BIN;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
            tick_q <= tick;
        end
    end

    assign TICK = tick_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [STABLE-1:0] hist_q;
            logic [STABLE-1:0] hist_d;
            logic              lvl_q;
            logic              lvl_d;
            logic              bout_q;
            logic              brel_q;
            logic              press_ev;
            logic              rel_ev;
            logic              rpt_pulse;

            always_comb begin
                hist_d   = hist_q;
                lvl_d    = lvl_q;
                press_ev = 1'b0;
                rel_ev   = 1'b0;
                if (tick) begin
                    hist_d = {hist_q[STABLE-2:0], sync_q[gi]};
                    if (hist_d == '0 && !lvl_q) begin
                        lvl_d    = 1'b1;
                        press_ev = 1'b1;
                    end else if (hist_d == '1 && lvl_q) begin
                        lvl_d  = 1'b0;
                        rel_ev = 1'b1;
                    end
                end
            end

`ifdef BTN_AUTO_REPEAT_EN
            rpt_state_e    state_q;
            rpt_state_e    state_d;
            logic [RW-1:0] rcnt_q;
            logic [RW-1:0] rcnt_d;

            // Release wins over everything, so a release tick never repeats.
            always_comb begin
                state_d   = state_q;
                rcnt_d    = rcnt_q;
                rpt_pulse = 1'b0;
                if (rel_ev) begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end else if (press_ev) begin
                    state_d = RPT_HOLD;
                    rcnt_d  = '0;
                end else if (tick) begin
                    case (state_q)
                        RPT_HOLD: begin
                            if (rcnt_q == RW'(RPT_DELAY - 1)) begin
                                rpt_pulse = 1'b1;
                                rcnt_d    = '0;
                                state_d   = RPT_REPEAT;
                            end else begin
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rcnt_q == RW'(RPT_RATE - 1)) begin
                                rpt_pulse = 1'b1;
                                rcnt_d    = '0;
                            end else begin
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (RST) begin
                    state_q <= RPT_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    state_q <= state_d;
                    rcnt_q  <= rcnt_d;
                end
            end
`else
            assign rpt_pulse = 1'b0;
`endif

            always_ff @(posedge CLOCK_50) begin
                if (RST) begin
                    hist_q <= '1;
                    lvl_q  <= 1'b0;
                    bout_q <= 1'b0;
                    brel_q <= 1'b0;
                end else begin
                    hist_q <= hist_d;
                    lvl_q  <= lvl_d;
                    bout_q <= press_ev | rpt_pulse;
                    brel_q <= rel_ev;
                end
            end

            assign BOUT[gi] = bout_q;
            assign BREL[gi] = brel_q;
            assign BLVL[gi] = lvl_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_in_rpt.sv
// Randomised and directed bench for btn_in_rpt against a run-length / tick-count model.
// Honours BTN_AUTO_REPEAT_EN in the same way as the design.
module tb_btn_in_rpt;

    localparam int N         = 3;
    localparam int DIV       = 4;
    localparam int STABLE    = 2;
    localparam int RPT_DELAY = 3;
    localparam int RPT_RATE  = 2;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] bin;
    logic [N-1:0] bout;
    logic [N-1:0] brel;
    logic [N-1:0] blvl;
    logic         tick;

    btn_in_rpt #(
        .N(N), .DIV(DIV), .STABLE(STABLE), .RPT_DELAY(RPT_DELAY), .RPT_RATE(RPT_RATE)
    ) dut (
        .CLOCK_50(clk),
        .RST(rst),
        .BIN(bin),
        .BOUT(bout),
        .BREL(brel),
        .BLVL(blvl),
        .TICK(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int tick_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp_v);
        end
    endtask

    // Reference model: button state from run length of equal samples,
    // repeats from the number of ticks the button has been held.
    int unsigned  cyc;
    logic [N-1:0] s1, s2, lvl_m, last_m, e_bout, e_brel;
    logic         e_tick;
    int           run_m [N];
    int           held_m [N];

    function automatic bit is_rpt(input int h);
        return (h == RPT_DELAY) || (h > RPT_DELAY && ((h - RPT_DELAY) % RPT_RATE) == 0);
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] b);
        if (r) begin
            cyc    = 0;
            s1     = '1;
            s2     = '1;
            lvl_m  = '0;
            last_m = '1;
            e_bout = '0;
            e_brel = '0;
            e_tick = 1'b0;
            for (int i = 0; i < N; i++) begin
                run_m[i]  = STABLE;
                held_m[i] = 0;
            end
            return;
        end
        e_tick = ((cyc % DIV) == DIV - 1);
        cyc++;
        e_bout = '0;
        e_brel = '0;
        if (e_tick) begin
            for (int i = 0; i < N; i++) begin
                if (s2[i] == last_m[i]) run_m[i]++;
                else begin
                    run_m[i]  = 1;
                    last_m[i] = s2[i];
                end
                if (lvl_m[i]) held_m[i]++;
                if (!lvl_m[i] && s2[i] == 1'b0 && run_m[i] >= STABLE) begin
                    lvl_m[i]  = 1'b1;
                    e_bout[i] = 1'b1;
                    held_m[i] = 0;
                end else if (lvl_m[i] && s2[i] == 1'b1 && run_m[i] >= STABLE) begin
                    lvl_m[i]  = 1'b0;
                    e_brel[i] = 1'b1;
                    held_m[i] = 0;
                end else if (RPT_EN && lvl_m[i] && is_rpt(held_m[i])) begin
                    e_bout[i] = 1'b1;
                end
            end
        end
        s2 = s1;
        s1 = b;
    endtask

    task automatic step();
        logic r_v;
        logic [N-1:0] b_v;
        r_v = rst;
        b_v = bin;
        @(posedge clk);
        model_edge(r_v, b_v);
        #1;
        if (tick === 1'b1) tick_seen++;
        check_val("out{tick,lvl,rel,press}", {22'd0, tick, blvl, brel, bout},
                  {22'd0, e_tick, lvl_m, e_brel, e_bout});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1;
        bin = '1;
        steps(2);
        rst = 1'b0;

        // idle: no events, TICK every DIV cycles
        tick_seen = 0;
        steps(100);
        check_val("idle_tick_count", tick_seen, 100 / DIV);

        // single press / release on channel 0
        bin[0] = 1'b0;
        steps(20);
        bin[0] = 1'b1;
        steps(20);

        // bounce on channel 1: toggle every tick for 10 ticks
        for (int t = 0; t < 10; t++) begin
            bin[1] = ~bin[1];
            steps(DIV);
        end
        bin[1] = 1'b1;
        steps(20);

        // simultaneous press on channels 0 and 2
        bin = 3'b010;
        steps(20);
        bin = 3'b111;
        steps(20);

        // long hold on channel 1
        bin[1] = 1'b0;
        steps(40);
        bin[1] = 1'b1;
        steps(20);

        // reset mid-repeat while still held
        bin[1] = 1'b0;
        steps(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(30);
        bin[1] = 1'b1;
        steps(20);

        // randomised bouncing, holds and occasional reset
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) bin[i] = ~bin[i];
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        bin = '1;
        steps(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
